// File: rtl/kt_pkg.sv
// Shared constants and the state type for the knight's-tour command sequencer.
package kt_pkg;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = $clog2(NUM_MOVES);

  localparam logic [3:0] OP_CAL      = 4'h2;
  localparam logic [3:0] OP_MOVE     = 4'h4;
  localparam logic [3:0] OP_MOVE_FAN = 4'h5;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_WAIT_V,
    ST_HORZ,
    ST_WAIT_H
  } tour_state_t;

endpackage

// File: rtl/move_decode.sv
// Turns a one-hot knight move into a vertical-leg and a horizontal-leg command.
// Lowest set bit wins; an empty move yields zero-square legs.
module move_decode
  import kt_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o
);

  logic       dy_pos, dx_pos;
  logic [3:0] dy_sq, dx_sq;

  always_comb begin
    dy_pos = 1'b0;
    dx_pos = 1'b0;
    dy_sq  = 4'd0;
    dx_sq  = 4'd0;
    casez (move_i)
      8'b???????1: begin dy_pos = 1'b1; dy_sq = 4'd2; dx_pos = 1'b0; dx_sq = 4'd1; end
      8'b??????10: begin dy_pos = 1'b1; dy_sq = 4'd2; dx_pos = 1'b1; dx_sq = 4'd1; end
      8'b?????100: begin dy_pos = 1'b0; dy_sq = 4'd1; dx_pos = 1'b0; dx_sq = 4'd2; end
      8'b????1000: begin dy_pos = 1'b1; dy_sq = 4'd1; dx_pos = 1'b0; dx_sq = 4'd2; end
      8'b???10000: begin dy_pos = 1'b0; dy_sq = 4'd2; dx_pos = 1'b0; dx_sq = 4'd1; end
      8'b??100000: begin dy_pos = 1'b0; dy_sq = 4'd2; dx_pos = 1'b1; dx_sq = 4'd1; end
      8'b?1000000: begin dy_pos = 1'b0; dy_sq = 4'd1; dx_pos = 1'b1; dx_sq = 4'd2; end
      8'b10000000: begin dy_pos = 1'b1; dy_sq = 4'd1; dx_pos = 1'b1; dx_sq = 4'd2; end
      default:     begin dy_pos = 1'b0; dy_sq = 4'd0; dx_pos = 1'b0; dx_sq = 4'd0; end
    endcase
  end

  assign vert_cmd_o = {OP_MOVE,     dy_pos ? HDG_N : HDG_S, dy_sq};
  assign horz_cmd_o = {OP_MOVE_FAN, dx_pos ? HDG_E : HDG_W, dx_sq};

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Arbitrates the cmd_proc command port between the UART path and the tour replay.
// Optional early abort on a pending UART command: define TOUR_ABORT_EN.
module tour_cmd_sequencer
  import kt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_aborted
);

  tour_state_t      state_q;
  logic [IDX_W-1:0] mv_indx_q;
  logic [7:0]       move_q;
  logic [15:0]      vert_cmd, horz_cmd;
  logic             last_move, abort_hit, abort_pulse;

  move_decode u_move_decode (
    .move_i     (move_q),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd)
  );

  assign last_move = (mv_indx_q == IDX_W'(NUM_MOVES - 1));

`ifdef TOUR_ABORT_EN
  logic abort_q;

  // Flag survives until the next leg completes so a command never cuts a leg short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  abort_q <= 1'b0;
    else if (state_q == ST_IDLE) abort_q <= 1'b0;
    else if (cmd_rdy_UART)       abort_q <= 1'b1;
  end

  assign abort_hit = abort_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mv_indx_q <= '0;
      move_q    <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE:
          if (start_tour) begin
            state_q   <= ST_VERT;
            mv_indx_q <= '0;
            move_q    <= move;
          end
        ST_VERT:
          if (clr_cmd_rdy) state_q <= ST_WAIT_V;
        ST_WAIT_V:
          if (send_resp) state_q <= abort_hit ? ST_IDLE : ST_HORZ;
        ST_HORZ:
          if (clr_cmd_rdy) state_q <= ST_WAIT_H;
        ST_WAIT_H:
          if (send_resp) begin
            if (abort_hit || last_move) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_VERT;
              mv_indx_q <= mv_indx_q + IDX_W'(1);
              move_q    <= move;
            end
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    abort_pulse      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy          = cmd_rdy_UART & ~start_tour;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
      end
      ST_WAIT_V: begin
        cmd         = vert_cmd;
        abort_pulse = abort_hit & send_resp;
        if (abort_pulse) resp = RESP_ACK;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      ST_WAIT_H: begin
        cmd         = horz_cmd;
        abort_pulse = abort_hit & send_resp;
        if (abort_pulse || last_move) resp = RESP_ACK;
      end
      default: ;
    endcase
  end

  assign mv_indx      = mv_indx_q;
  assign tour_aborted = abort_pulse;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer (default build): passthrough, full tour, reset mid-tour.
module tb_tour_cmd_sequencer;

  localparam int NM = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_aborted;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [7:0] moves [NM] = '{8'h40, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h80,
                             8'h00, 8'h48, 8'hC0, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30,
                             8'h60, 8'hFF, 8'h41, 8'h22, 8'h84, 8'h11, 8'h88, 8'h05};
  int dy_t [8] = '{2, 2, -1, 1, -2, -2, -1, 1};
  int dx_t [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};

  tour_cmd_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .tour_aborted     (tour_aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference legs from the dy/dx table of the move set.
  task automatic push_legs(input logic [7:0] m);
    int dy = 0;
    int dx = 0;
    bit found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        dy = dy_t[i];
        dx = dx_t[i];
        found = 1'b1;
      end
    end
    exp_q.push_back({4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)});
    exp_q.push_back({4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)});
  endtask

  // One leg served by a cmd_proc model: accept, delay, respond.
  task automatic do_leg(input int k, input bit horiz);
    int n = 0;
    logic [15:0] e;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) chk("leg_timeout", 16'(cmd_rdy), 16'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
    chk(horiz ? "horz_cmd" : "vert_cmd", cmd, e);
    chk("leg_idx", 16'(mv_indx), 16'(k));
    chk("leg_resp", 16'(resp), 16'h005A);
    clr_cmd_rdy = 1'b1;
    #1 chk("uart_blocked", 16'(clr_cmd_rdy_UART), 16'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1 chk("accept_drop", 16'(cmd_rdy), 16'd0);
    @(negedge clk);
    @(negedge clk);
    if (horiz && k < NM - 1) move = moves[k + 1];
    send_resp = 1'b1;
    #1 chk("done_resp", 16'(resp), (horiz && k == NM - 1) ? 16'h00A5 : 16'h005A);
    @(negedge clk);
    send_resp = 1'b0;
    #1;
    if (!(horiz && k == NM - 1)) chk("next_rdy", 16'(cmd_rdy), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; start_tour = 1'b0; move = 8'h00; cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    @(negedge clk); #1;
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
    chk("rst_idx", 16'(mv_indx), 16'd0);
    chk("rst_resp", 16'(resp), 16'h00A5);
    chk("rst_abort", 16'(tour_aborted), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // UART passthrough in IDLE
    @(negedge clk);
    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
    #1 chk("pass_cmd", cmd, 16'h2000);
    chk("pass_rdy", 16'(cmd_rdy), 16'd1);
    chk("pass_resp", 16'(resp), 16'h00A5);
    clr_cmd_rdy = 1'b1;
    #1 chk("pass_clr", 16'(clr_cmd_rdy_UART), 16'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Full tour
    foreach (moves[i]) push_legs(moves[i]);
    @(negedge clk);
    move = moves[0]; start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    #1 chk("start_rdy", 16'(cmd_rdy), 16'd1);
    // send_resp before accept and start_tour outside IDLE must both be ignored
    send_resp = 1'b1; start_tour = 1'b1; move = 8'h01;
    @(negedge clk);
    send_resp = 1'b0; start_tour = 1'b0; move = moves[0];
    #1 chk("vert_hold", 16'(cmd_rdy), 16'd1);
    for (int k = 0; k < NM; k++) begin
      if (k == 2) begin
        cmd_UART = 16'h2123; cmd_rdy_UART = 1'b1;
      end
      do_leg(k, 1'b0);
      do_leg(k, 1'b1);
    end
    chk("end_idx", 16'(mv_indx), 16'd23);
    chk("end_resp", 16'(resp), 16'h00A5);
    chk("end_uart_rdy", 16'(cmd_rdy), 16'd1);
    chk("end_uart_cmd", cmd, 16'h2123);
    chk("end_abort", 16'(tour_aborted), 16'd0);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    clr_cmd_rdy = 1'b1;
    #1 chk("end_uart_clr", 16'(clr_cmd_rdy_UART), 16'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Second tour; start_tour masks a pending UART command, then reset in HORZ
    exp_q.delete();
    push_legs(moves[0]); push_legs(moves[1]);
    @(negedge clk);
    cmd_UART = 16'h2456; cmd_rdy_UART = 1'b1; move = moves[0]; start_tour = 1'b1;
    #1 chk("start_mask", 16'(cmd_rdy), 16'd0);
    @(negedge clk);
    start_tour = 1'b0; cmd_rdy_UART = 1'b0;
    do_leg(0, 1'b0);
    do_leg(0, 1'b1);
    do_leg(1, 1'b0);
    chk("horz_idx", 16'(mv_indx), 16'd1);
    cmd_rdy_UART = 1'b1; #1;
    rst_n = 1'b0;
    #1 chk("arst_rdy", 16'(cmd_rdy), 16'd1);
    chk("arst_idx", 16'(mv_indx), 16'd0);
    chk("arst_cmd", cmd, 16'h2456);
    chk("arst_resp", 16'(resp), 16'h00A5);
    @(negedge clk);
    rst_n = 1'b1; cmd_rdy_UART = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
